// File: rtl/cmd_decoder_if.sv
// cmd_decoder_if: byte-source handshake plus font/text/pixel write bus of cmd_decoder
interface cmd_decoder_if #(
  parameter int TEXT_AW = 13
);
  logic               has_data;
  logic [7:0]         rd_data;
  logic               rd;
  logic               font_we;
  logic [11:0]        font_addr;
  logic [7:0]         font_wdata;
  logic               text_we;
  logic [TEXT_AW-1:0] text_addr;
  logic [7:0]         text_wdata;
  logic [7:0]         pixreg;
  logic               busy;
  logic               bad_cmd;
  modport master (
    output has_data, rd_data,
    input  rd, font_we, font_addr, font_wdata, text_we, text_addr, text_wdata, pixreg, busy, bad_cmd
  );
  modport slave (
    input  has_data, rd_data,
    output rd, font_we, font_addr, font_wdata, text_we, text_addr, text_wdata, pixreg, busy, bad_cmd
  );
endinterface

// File: rtl/cmd_decoder.sv
// cmd_decoder: decodes a byte stream (bus.has_data/rd_data in, bus.rd out) into font/text memory writes, pixreg, busy and sticky bad_cmd
module cmd_decoder #(
  parameter int FONT_BYTES = 4096,
  parameter int TEXT_AW    = 13
) (
  input logic          clk,
  input logic          rst,
  cmd_decoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FONT_DATA, PIX_DATA, ADDR_LO, ADDR_HI, TXT_COUNT, TXT_DATA} state_t;
  localparam logic [11:0] FONT_LAST = 12'(FONT_BYTES - 1);
  state_t             r_state;
  logic               r_rd, r_vld, r_font_we, r_text_we, r_bad;
  logic [7:0]         r_byte, r_font_wdata, r_text_wdata, r_pix;
  logic [11:0]        r_fcnt, r_font_addr;
  logic [8:0]         r_tcnt;
  logic [TEXT_AW-1:0] r_ptr, r_text_addr;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rd         <= 1'b0;
      r_vld        <= 1'b0;
      r_byte       <= 8'h00;
      r_font_we    <= 1'b0;
      r_font_addr  <= 12'h000;
      r_font_wdata <= 8'h00;
      r_text_we    <= 1'b0;
      r_text_addr  <= '0;
      r_text_wdata <= 8'h00;
      r_pix        <= 8'h00;
      r_bad        <= 1'b0;
      r_fcnt       <= 12'h000;
      r_tcnt       <= 9'd0;
      r_ptr        <= '0;
    end else begin
      r_rd      <= bus.has_data & ~r_rd;
      r_vld     <= r_rd;
      r_font_we <= 1'b0;
      r_text_we <= 1'b0;
      if (r_rd) r_byte <= bus.rd_data;
      if (r_vld) begin
        case (r_state)
          IDLE: begin
            case (r_byte)
              8'h00: r_state <= IDLE;
              8'h80: begin
                r_state <= FONT_DATA;
                r_fcnt  <= 12'h000;
              end
              8'h81: r_state <= PIX_DATA;
              8'h82: r_state <= ADDR_LO;
              8'h83: r_state <= TXT_COUNT;
              default: r_bad <= 1'b1;
            endcase
          end
          FONT_DATA: begin
            r_font_we    <= 1'b1;
            r_font_addr  <= r_fcnt;
            r_font_wdata <= r_byte;
            r_fcnt       <= r_fcnt + 12'd1;
            if (r_fcnt == FONT_LAST) r_state <= IDLE;
          end
          PIX_DATA: begin
            r_pix   <= r_byte;
            r_state <= IDLE;
          end
          ADDR_LO: begin
            r_ptr   <= TEXT_AW'({r_ptr[TEXT_AW-1:8], r_byte});
            r_state <= ADDR_HI;
          end
          ADDR_HI: begin
            r_ptr   <= TEXT_AW'({r_byte, r_ptr[7:0]});
            r_state <= IDLE;
          end
          TXT_COUNT: begin
            r_tcnt  <= {r_byte == 8'h00, r_byte};
            r_state <= TXT_DATA;
          end
          TXT_DATA: begin
            r_text_we    <= 1'b1;
            r_text_addr  <= r_ptr;
            r_text_wdata <= r_byte;
            r_ptr        <= r_ptr + TEXT_AW'(1);
            r_tcnt       <= r_tcnt - 9'd1;
            if (r_tcnt == 9'd1) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign bus.rd         = r_rd;
  assign bus.font_we    = r_font_we;
  assign bus.font_addr  = r_font_addr;
  assign bus.font_wdata = r_font_wdata;
  assign bus.text_we    = r_text_we;
  assign bus.text_addr  = r_text_addr;
  assign bus.text_wdata = r_text_wdata;
  assign bus.pixreg     = r_pix;
  assign bus.busy       = r_state != IDLE;
  assign bus.bad_cmd    = r_bad;
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: directed byte streams with a write-event scoreboard for cmd_decoder
module tb_cmd_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cmd_decoder_if #(.TEXT_AW(13)) bus();
  cmd_decoder #(.FONT_BYTES(4096), .TEXT_AW(13)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {logic t; logic [12:0] a; logic [7:0] d;} ev_t;
  ev_t q[$];
  ev_t e_exp, e_got;
  int n_vec = 0;
  int n_bad = 0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (bus.font_we || bus.text_we) begin
      n_vec++;
      e_got = {bus.text_we, bus.text_we ? bus.text_addr : {1'b0, bus.font_addr},
               bus.text_we ? bus.text_wdata : bus.font_wdata};
      if (bus.font_we && bus.text_we) begin
        n_bad++;
        $display("FAIL we_overlap: font_we and text_we both high at %0t", $time);
      end else if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got text=%0b addr=%h data=%h, required no write", e_got.t, e_got.a, e_got.d);
      end else begin
        e_exp = q.pop_front();
        if (e_got !== e_exp) begin
          n_bad++;
          $display("FAIL write: got text=%0b addr=%h data=%h, required text=%0b addr=%h data=%h",
                   e_got.t, e_got.a, e_got.d, e_exp.t, e_exp.a, e_exp.d);
        end
      end
    end
    if (bus.rd && prev_rd) begin
      n_vec++;
      n_bad++;
      $display("FAIL rd_spacing: rd high two cycles in a row at %0t", $time);
    end
    prev_rd = bus.rd;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  function automatic void exp_w(input logic t, input logic [12:0] a, input logic [7:0] d);
    q.push_back({t, a, d});
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    int k = 0;
    bus.has_data = 1'b1;
    bus.rd_data  = b;
    @(negedge clk);
    while (!bus.rd && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.rd) begin
      n_vec++;
      n_bad++;
      $display("FAIL rd_timeout: no rd for byte %h, required rd within 20 cycles", b);
    end
    @(posedge clk);
    #1;
    bus.has_data = 1'b0;
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_rd"}, 32'(bus.rd), 0);
    chk({nm, "_font_we"}, 32'(bus.font_we), 0);
    chk({nm, "_text_we"}, 32'(bus.text_we), 0);
    chk({nm, "_font_addr"}, 32'(bus.font_addr), 0);
    chk({nm, "_font_wdata"}, 32'(bus.font_wdata), 0);
    chk({nm, "_text_addr"}, 32'(bus.text_addr), 0);
    chk({nm, "_text_wdata"}, 32'(bus.text_wdata), 0);
    chk({nm, "_pixreg"}, 32'(bus.pixreg), 0);
    chk({nm, "_busy"}, 32'(bus.busy), 0);
    chk({nm, "_bad_cmd"}, 32'(bus.bad_cmd), 0);
  endtask
  initial begin
    bus.has_data = 1'b0;
    bus.rd_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    idle(2);
    send(8'h81);
    send(8'hA5);
    idle(4);
    chk("pix_a5", 32'(bus.pixreg), 32'hA5);
    chk("pix_busy_done", 32'(bus.busy), 0);
    send(8'h81);
    idle(3);
    chk("pix_busy_mid", 32'(bus.busy), 1);
    idle(10);
    chk("hold_busy", 32'(bus.busy), 1);
    send(8'h5A);
    idle(3);
    chk("pix_5a", 32'(bus.pixreg), 32'h5A);
    send(8'h55);
    idle(3);
    chk("bad_set", 32'(bus.bad_cmd), 1);
    chk("bad_busy", 32'(bus.busy), 0);
    send(8'h81);
    send(8'h01);
    idle(3);
    chk("bad_pix_01", 32'(bus.pixreg), 32'h01);
    chk("bad_sticky", 32'(bus.bad_cmd), 1);
    send(8'h00);
    idle(3);
    chk("nop_busy", 32'(bus.busy), 0);
    exp_w(1'b1, 13'h1FFF, 8'h41);
    exp_w(1'b1, 13'h0000, 8'h42);
    exp_w(1'b1, 13'h0001, 8'h43);
    send(8'h82);
    send(8'hFF);
    send(8'h1F);
    send(8'h83);
    send(8'h03);
    send(8'h41);
    send(8'h42);
    send(8'h43);
    idle(4);
    chk("txt_wrap_busy", 32'(bus.busy), 0);
    chk("txt_wrap_addr", 32'(bus.text_addr), 32'h0001);
    send(8'h83);
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      exp_w(1'b1, 13'(i + 2), 8'(i));
      send(8'(i));
    end
    idle(4);
    chk("txt256_busy", 32'(bus.busy), 0);
    chk("txt256_q", 32'(q.size()), 0);
    send(8'h81);
    send(8'hC3);
    idle(3);
    chk("txt256_pix", 32'(bus.pixreg), 32'hC3);
    send(8'h80);
    for (int i = 0; i < 4096; i++) begin
      exp_w(1'b0, 13'(i), 8'(i));
      send(8'(i));
    end
    idle(4);
    chk("font_busy", 32'(bus.busy), 0);
    chk("font_q", 32'(q.size()), 0);
    send(8'h81);
    send(8'h3C);
    idle(3);
    chk("font_pix", 32'(bus.pixreg), 32'h3C);
    send(8'h80);
    for (int i = 0; i < 100; i++) begin
      exp_w(1'b0, 13'(i), 8'(i + 7));
      send(8'(i + 7));
    end
    idle(4);
    chk("midrst_busy_before", 32'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    send(8'h81);
    send(8'h99);
    idle(4);
    chk("midrst_pix", 32'(bus.pixreg), 32'h99);
    chk("midrst_font_addr", 32'(bus.font_addr), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("final_q", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
